mc_controller: RTL and testbench

Multi-cycle control FSM for the MIPS core. It replaces the single-cycle combinational controller when the datapath is refactored to share one memory and one ALU across cycles. Each cycle it decodes the latched instruction register fields and the ALU `zero` flag, then drives every datapath enable and mux select. It supports lw, sw, R-type (add/sub/and/or/slt), beq, j and, optionally, addi.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/mc_aludec.sv | 21 ++
 rtl/mc_controller.sv | 137 +++++++++++++
 tb/tb_mc_controller.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, funct codes, ALU/select codes and multi-cycle state encoding; MC_ADDI_EN adds addi states
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
`ifdef MC_ADDI_EN
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11
    } state_t;
`else
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, JEX = 4'd11
    } state_t;
`endif
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: R-type funct to ALU control decode, flagging unsupported funct
module mc_aludec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] aluctrl,
    output logic       bad
);
    always_comb begin
        aluctrl = ALU_ADD;
        bad = 1'b0;
        case (funct)
            F_ADD:   aluctrl = ALU_ADD;
            F_SUB:   aluctrl = ALU_SUB;
            F_AND:   aluctrl = ALU_AND;
            F_OR:    aluctrl = ALU_OR;
            F_SLT:   aluctrl = ALU_SLT;
            default: bad = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM (lw/sw/R-type/beq/j); define MC_ADDI_EN to add addi
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluctrl,
    output logic       instr_done,
    output logic       illegal
);
    state_t state, next_state;
    logic [2:0] rtype_alu;
    logic bad_funct;

    mc_aludec u_aludec (.funct(funct), .aluctrl(rtype_alu), .bad(bad_funct));

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= FETCH;
        else state <= next_state;

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE:
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = bad_funct ? FETCH : RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_J:         next_state = JEX;
`ifdef MC_ADDI_EN
                    OP_ADDI:      next_state = ADDIEX;
`endif
                    default:      next_state = FETCH;
                endcase
            MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
`ifdef MC_ADDI_EN
            ADDIEX:  next_state = ADDIWB;
`endif
            default: next_state = FETCH;
        endcase
    end

    // Only DECODE can fall straight back to FETCH, and only for an unsupported instruction
    assign illegal = (state == DECODE) && (next_state == FETCH);

    always_comb begin
        pcen = 1'b0;
        irwrite = 1'b0;
        iord = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        regdst = 1'b0;
        regwrite = 1'b0;
        alusrca = 1'b0;
        alusrcb = SRCB_B;
        pcsrc = PC_ALU;
        aluctrl = ALU_AND;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                irwrite = 1'b1;
                pcen = 1'b1;
                alusrcb = SRCB_4;
                aluctrl = ALU_ADD;
            end
            DECODE: begin
                alusrcb = SRCB_IMMSH;
                aluctrl = ALU_ADD;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluctrl = ALU_ADD;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                memwrite = 1'b1;
                instr_done = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluctrl = rtype_alu;
            end
            RTYPEWB: begin
                regdst = 1'b1;
                regwrite = 1'b1;
                instr_done = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluctrl = ALU_SUB;
                pcsrc = PC_ALUOUT;
                pcen = zero;
                instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluctrl = ALU_ADD;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                instr_done = 1'b1;
            end
`endif
            JEX: begin
                pcsrc = PC_JUMP;
                pcen = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: random instruction stream against a per-instruction cycle-table model
module tb_mc_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic zero = 1'b0;
    logic pcen, irwrite, iord, memwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctrl;
    logic instr_done, illegal;
    int checks = 0;
    int failures = 0;

    mc_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluctrl(aluctrl),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // bundle order: pcen irwrite iord memwrite memtoreg regdst regwrite alusrca alusrcb pcsrc aluctrl done illegal
    function automatic logic [16:0] got_vec();
        return {pcen, irwrite, iord, memwrite, memtoreg, regdst, regwrite, alusrca,
                alusrcb, pcsrc, aluctrl, instr_done, illegal};
    endfunction

    function automatic logic [16:0] mk(input logic pe, irw, io, mw, mtr, rd, rw, asa,
                                       input logic [1:0] b, p, input logic [2:0] alu,
                                       input logic done, ill);
        return {pe, irw, io, mw, mtr, rd, rw, asa, b, p, alu, done, ill};
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    // instruction classes: 0 lw, 1 sw, 2 rtype, 3 beq, 4 j, 5 addi, 6 illegal
    function automatic int alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return -1;
        endcase
    endfunction

    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return 0;
            6'b101011: return 1;
            6'b000000: return (alu_of(f) < 0) ? 6 : 2;
            6'b000100: return 3;
            6'b000010: return 4;
`ifdef MC_ADDI_EN
            6'b001000: return 5;
`endif
            default:   return 6;
        endcase
    endfunction

    function automatic int cycles_of(input int kind);
        case (kind)
            0: return 5;
            1, 2, 5: return 4;
            3, 4: return 3;
            default: return 2;
        endcase
    endfunction

    localparam logic [16:0] FETCH_V = {1'b1, 1'b1, 6'b0, 2'b01, 2'b00, 3'b010, 2'b00};

    function automatic logic [16:0] expect_out(input int kind, input int k, input logic [5:0] f,
                                               input logic z);
        logic [2:0] ra;
        ra = 3'(alu_of(f));
        if (k == 0) return FETCH_V;
        if (k == 1) return mk(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0, kind == 6);
        case (kind)
            0, 1: if (k == 2) return mk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0, 0);
                  else if (kind == 0 && k == 3) return mk(0,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
                  else if (kind == 0) return mk(0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 1, 0);
                  else return mk(0,0,1,1,0,0,0,0, 2'b00, 2'b00, 3'b000, 1, 0);
            2: return (k == 2) ? mk(0,0,0,0,0,0,0,1, 2'b00, 2'b00, ra, 0, 0)
                               : mk(0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b000, 1, 0);
            3: return mk(z,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 1, 0);
            4: return mk(1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 1, 0);
            5: return (k == 2) ? mk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0, 0)
                               : mk(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b000, 1, 0);
            default: return 17'h1ffff;
        endcase
    endfunction

    // called at a negedge in the FETCH cycle; zsel 0/1 forces zero, 2 randomizes it every cycle
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f, input int zsel);
        int kind;
        kind = kind_of(o, f);
        op = o;
        funct = f;
        for (int k = 0; k < cycles_of(kind); k++) begin
            zero = (zsel == 2) ? 1'($urandom) : 1'(zsel);
            #1;
            check($sformatf("%s.c%0d", tag, k), got_vec(), expect_out(kind, k, f, zero));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    logic [5:0] ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
                            6'b000010, 6'b001000, 6'b111111};
    logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    initial begin
        #3;
        check("reset_async", got_vec(), FETCH_V);
        @(posedge clk);
        #1;
        check("reset_held", got_vec(), FETCH_V);
        @(negedge clk);
        rst = 1'b0;
        run_instr("lw", 6'b100011, 6'b000000, 2);
        run_instr("sub", 6'b000000, 6'b100010, 2);
        run_instr("beq_z1", 6'b000100, 6'b000000, 1);
        run_instr("beq_z0", 6'b000100, 6'b000000, 0);
        run_instr("ill_op", 6'b111111, 6'b000000, 2);
        run_instr("ill_fn", 6'b000000, 6'b000111, 2);
        run_instr("addi", 6'b001000, 6'b000000, 2);
        run_instr("j", 6'b000010, 6'b000000, 2);
        for (int i = 0; i < 300; i++) begin
            logic [5:0] o, f;
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            f = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr($sformatf("rnd%0d", i), o, f, 2);
        end
        // abort a store in MEMWR with an asynchronous mid-cycle reset
        op = 6'b101011;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("sw_abort.c%0d", k), got_vec(), expect_out(1, k, 6'd0, zero));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("sw_abort.memwr", got_vec(), expect_out(1, 3, 6'd0, zero));
        #1;
        rst = 1'b1;
        #1;
        check("sw_abort.rst", got_vec(), FETCH_V);
        @(posedge clk);
        @(negedge clk);
        check("sw_abort.rst_edge", got_vec(), FETCH_V);
        rst = 1'b0;
        run_instr("lw_after_rst", 6'b100011, 6'b000000, 2);
        run_instr("final", 6'b000010, 6'b000000, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end
endmodule
